// File: rtl/sdm_pkg.sv
// Shared state encoding and helpers for the serial packet demultiplexer.
package sdm_pkg;
   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      LEN  = 3'd2,
      DATA = 3'd3,
      PAR  = 3'd4,
      DONE = 3'd5,
      ERR  = 3'd6
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/sdm_shift_reg.sv
// Serial-in parallel-out shift register, MSB = oldest bit, async active-low reset.
module sdm_shift_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         en,
   input  logic         din,
   output logic [W-1:0] q
);
   logic [W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (en) q_d = (q_q << 1) | W'(din);
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) q_q <= '0;
      else        q_q <= q_d;
   end

   assign q = q_q;
endmodule

// File: rtl/serial_packet_demux.sv
// Serial packet demultiplexer: start bit, address, length, payload routed to a one-hot channel.
// Optional even-parity bit after the payload when SDM_PARITY_EN is defined.
//
//   state | meaning
//   IDLE  | line idle-high, waiting for a start bit (sin=0)
//   ADDR  | shifting in the channel address, MSB first
//   LEN   | shifting in the payload length, MSB first
//   DATA  | forwarding payload bits to the selected channel
//   PAR   | checking the even-parity bit (SDM_PARITY_EN only)
//   DONE  | one-cycle done pulse, back to IDLE
//   ERR   | one-cycle error pulse, back to IDLE
module serial_packet_demux
   import sdm_pkg::*;
#(
   parameter int NCH    = 4,
   parameter int ADDR_W = 2,
   parameter int LEN_W  = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sin,
   output logic [NCH-1:0]    p,
   output logic              dout,
   output logic              outvalid,
   output logic              error,
   output logic              done,
   output logic [2:0]        cur,
   output logic [LEN_W-1:0]  fl,
   output logic [DATA_W-1:0] shift_out
);
   localparam int CNT_W = $clog2(max_int(ADDR_W, LEN_W) + 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  fl_q, fl_d;
   logic [NCH-1:0]    p_q, p_d;
   logic              outvalid_q, outvalid_d;
   logic              error_q, error_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] addr_q, addr_nx;
   logic [LEN_W-1:0]  len_q, len_nx;
   logic              last_bit;
   logic              addr_bad;
`ifdef SDM_PARITY_EN
   logic              par_q, par_d;
`endif

   sdm_shift_reg #(.W(ADDR_W)) u_addr_sr (
      .clk(clk), .rst_b(rst), .en(state_q == ADDR), .din(sin), .q(addr_q));

   sdm_shift_reg #(.W(LEN_W)) u_len_sr (
      .clk(clk), .rst_b(rst), .en(state_q == LEN), .din(sin), .q(len_q));

   sdm_shift_reg #(.W(DATA_W)) u_data_sr (
      .clk(clk), .rst_b(rst), .en(state_q == DATA), .din(sin), .q(shift_out));

   // Field value including the bit being sampled this cycle, so decisions happen on the last bit.
   assign addr_nx  = (addr_q << 1) | ADDR_W'(sin);
   assign len_nx   = (len_q << 1) | LEN_W'(sin);
   assign last_bit = (cnt_q == '0);
   assign addr_bad = (int'(addr_nx) >= NCH);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fl_d    = '0;
      case (state_q)
         IDLE: begin
            if (!sin) begin
               state_d = ADDR;
               cnt_d   = CNT_W'(ADDR_W - 1);
            end
         end
         ADDR: begin
            if (!last_bit)     cnt_d = cnt_q - CNT_W'(1);
            else if (addr_bad) state_d = ERR;
            else begin
               state_d = LEN;
               cnt_d   = CNT_W'(LEN_W - 1);
            end
         end
         LEN: begin
            if (!last_bit)          cnt_d = cnt_q - CNT_W'(1);
            else if (len_nx == '0)  state_d = ERR;
            else begin
               state_d = DATA;
               fl_d    = len_nx;
            end
         end
         DATA: begin
            fl_d = fl_q - LEN_W'(1);
            if (fl_q == LEN_W'(1)) begin
`ifdef SDM_PARITY_EN
               state_d = PAR;
`else
               state_d = DONE;
`endif
            end
         end
`ifdef SDM_PARITY_EN
         PAR:     state_d = (sin == par_q) ? DONE : ERR;
`endif
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      outvalid_d = (state_d == DATA);
      p_d        = outvalid_d ? (NCH'(1) << addr_q) : '0;
      error_d    = (state_d == ERR);
      done_d     = (state_d == DONE);
   end

`ifdef SDM_PARITY_EN
   always_comb begin
      par_d = par_q;
      if (state_q == IDLE)      par_d = 1'b0;
      else if (state_q == DATA) par_d = par_q ^ sin;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) par_q <= 1'b0;
      else      par_q <= par_d;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         fl_q       <= '0;
         p_q        <= '0;
         outvalid_q <= 1'b0;
         error_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fl_q       <= fl_d;
         p_q        <= p_d;
         outvalid_q <= outvalid_d;
         error_q    <= error_d;
         done_q     <= done_d;
      end
   end

   assign p        = p_q;
   assign outvalid = outvalid_q;
   assign dout     = outvalid_q & sin;
   assign error    = error_q;
   assign done     = done_q;
   assign cur      = state_q;
   assign fl       = fl_q;
endmodule

// File: tb/tb_serial_packet_demux.sv
// Self-checking bench for serial_packet_demux (NCH=4 main instance, NCH=3 side instance).
`timescale 1ns/1ps
module tb_serial_packet_demux;
   import sdm_pkg::*;

`ifdef SDM_PARITY_EN
   localparam bit PAR_ON = 1'b1;
`else
   localparam bit PAR_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sin = 1'b1;
   logic [3:0] p;
   logic       dout, outvalid, error, done;
   logic [2:0] cur;
   logic [3:0] fl;
   logic [7:0] shift_out;
   logic [2:0] p3;
   logic       dout3, outvalid3, error3, done3;
   logic [2:0] cur3;
   logic [3:0] fl3;
   logic [7:0] shift_out3;

   serial_packet_demux #(.NCH(4), .ADDR_W(2), .LEN_W(4), .DATA_W(8)) u_dut (
      .clk(clk), .rst(rst), .sin(sin), .p(p), .dout(dout), .outvalid(outvalid),
      .error(error), .done(done), .cur(cur), .fl(fl), .shift_out(shift_out));

   serial_packet_demux #(.NCH(3), .ADDR_W(2), .LEN_W(4), .DATA_W(8)) u_dut3 (
      .clk(clk), .rst(rst), .sin(sin), .p(p3), .dout(dout3), .outvalid(outvalid3),
      .error(error3), .done(done3), .cur(cur3), .fl(fl3), .shift_out(shift_out3));

   always #5 clk = ~clk;

   typedef struct {
      bit         is_err;
      int         addr;
      int         len;
      logic [14:0] payload;
      int         exp_cnt;
      logic [7:0] exp_so;
   } exp_t;

   typedef struct {
      logic [1:0]  addr;
      logic [3:0]  len;
      logic [14:0] payload;
      bit          bad_par;
   } vec_t;

   exp_t       sb[$];
   int         checks = 0;
   int         failures = 0;
   logic [7:0] so_model = '0;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
      end
   endtask

   task automatic send_bit(input logic b);
      @(posedge clk);
      #1 sin = b;
   endtask

   task automatic send_hdr(input logic [1:0] addr, input logic [3:0] len);
      send_bit(1'b0);
      for (int i = 1; i >= 0; i--) send_bit(addr[i]);
      for (int i = 3; i >= 0; i--) send_bit(len[i]);
   endtask

   task automatic push_exp(input logic [1:0] addr, input logic [3:0] len,
                           input logic [14:0] payload, input bit bad_par);
      exp_t e;
      e.is_err  = (len == 0) || (PAR_ON && bad_par);
      e.addr    = int'(addr);
      e.len     = int'(len);
      e.payload = payload;
      e.exp_cnt = int'(len);
      for (int i = int'(len) - 1; i >= 0; i--) so_model = {so_model[6:0], payload[i]};
      e.exp_so  = so_model;
      sb.push_back(e);
   endtask

   task automatic send_packet(input logic [1:0] addr, input logic [3:0] len,
                              input logic [14:0] payload, input bit bad_par);
      push_exp(addr, len, payload, bad_par);
      send_hdr(addr, len);
      for (int i = int'(len) - 1; i >= 0; i--) send_bit(payload[i]);
      if (PAR_ON && len != 0) send_bit((^payload) ^ bad_par);
      repeat (3) send_bit(1'b1);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
      #1 check(sb.size() == 0, name, sb.size(), 0);
   endtask

   // Scoreboard monitor for the NCH=4 instance, sampled on the falling edge.
   int          mon_cnt = 0;
   logic [14:0] mon_got = '0;
   logic [3:0]  mon_p = '0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         mon_cnt = 0;
         mon_got = '0;
         mon_p   = '0;
      end else begin
         check(!(error && done), "err_done_excl", int'(error), 0);
         if (outvalid) begin
            if (sb.size() == 0) check(1'b0, "ov_unexpected", 1, 0);
            else begin
               check(int'(fl) == sb[0].len - mon_cnt, "fl_count", int'(fl), sb[0].len - mon_cnt);
               check(cur == DATA, "cur_data", int'(cur), int'(DATA));
            end
            mon_got = {mon_got[13:0], dout};
            mon_p   = p;
            mon_cnt++;
         end else begin
            check(p == 0 && dout == 1'b0 && fl == 0, "idle_outs", int'({p, dout, fl}), 0);
         end
         if (done || error) begin
            if (sb.size() == 0) check(1'b0, "pulse_unexpected", int'({error, done}), 0);
            else begin
               e = sb.pop_front();
               check(error == e.is_err, "pkt_kind", int'(error), int'(e.is_err));
               check(mon_cnt == e.exp_cnt, "ov_cycles", mon_cnt, e.exp_cnt);
               if (done) begin
                  check(mon_p == (4'b1 << e.addr), "chan", int'(mon_p), int'(4'b1 << e.addr));
                  check(mon_got == e.payload, "payload", int'(mon_got), int'(e.payload));
                  check(shift_out == e.exp_so, "shift_out", int'(shift_out), int'(e.exp_so));
               end
            end
            mon_cnt = 0;
            mon_got = '0;
            mon_p   = '0;
         end
      end
   end

   int e3_cnt = 0, ov3_cnt = 0, p3_cnt = 0;
   always @(negedge clk) begin
      if (rst) begin
         if (error3)    e3_cnt++;
         if (outvalid3) ov3_cnt++;
         if (p3 != 0)   p3_cnt++;
      end
   end

   vec_t vecs[8];
   int   b_e3, b_ov3, b_p3;

   initial begin
      vecs[0] = '{2'd2, 4'd3,  15'b101,        1'b0};
      vecs[1] = '{2'd0, 4'd1,  15'b1,          1'b0};
      vecs[2] = '{2'd3, 4'd15, 15'h5A3C,       1'b0};
      vecs[3] = '{2'd1, 4'd8,  15'h00C3,       1'b0};
      vecs[4] = '{2'd2, 4'd0,  15'h0000,       1'b0};
      vecs[5] = '{2'd1, 4'd3,  15'b101,        1'b1};
      vecs[6] = '{2'd3, 4'd9,  15'h01F0,       1'b0};
      vecs[7] = '{2'd0, 4'd2,  15'b10,         1'b0};

      #95;
      check(cur == IDLE, "rst_cur", int'(cur), int'(IDLE));
      check(p == 0 && outvalid == 1'b0 && dout == 1'b0, "rst_route", int'({p, outvalid, dout}), 0);
      check(error == 1'b0 && done == 1'b0, "rst_pulses", int'({error, done}), 0);
      check(fl == 0 && shift_out == 0, "rst_regs", int'({fl, shift_out}), 0);
      #5 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 check(cur == IDLE && outvalid == 1'b0, "idle_hold", int'(cur), int'(IDLE));

      for (int i = 0; i < 8; i++)
         send_packet(vecs[i].addr, vecs[i].len, vecs[i].payload, vecs[i].bad_par);
      drain("table_drain");

      // Zero length: error exactly one cycle after the last length bit.
      push_exp(2'd1, 4'd0, 15'd0, 1'b0);
      send_hdr(2'd1, 4'd0);
      @(posedge clk);
      #1 check(error == 1'b1, "len0_err_pulse", int'(error), 1);
      sin = 1'b1;
      @(posedge clk);
      #1 check(error == 1'b0, "len0_err_width", int'(error), 0);
      repeat (3) send_bit(1'b1);
      drain("len0_drain");

      // Reset in the middle of an 8-bit payload.
      push_exp(2'd1, 4'd8, 15'h00A5, 1'b0);
      send_hdr(2'd1, 4'd8);
      for (int i = 7; i >= 4; i--) send_bit(i[0]);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check(cur == IDLE, "midrst_cur", int'(cur), int'(IDLE));
      check(outvalid == 1'b0 && error == 1'b0 && done == 1'b0, "midrst_outs",
            int'({outvalid, error, done}), 0);
      check(shift_out == 0 && fl == 0, "midrst_regs", int'({shift_out, fl}), 0);
      sb.delete();
      so_model = '0;
      sin = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) send_bit(1'b1);
      send_packet(2'd2, 4'd3, 15'b101, 1'b0);
      drain("post_rst_drain");

      // NCH=3 instance: address 3 out of range.
      @(posedge clk);
      #2 rst = 1'b0;
      so_model = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) send_bit(1'b1);
      b_e3 = e3_cnt; b_ov3 = ov3_cnt; b_p3 = p3_cnt;
      send_packet(2'd3, 4'd7, 15'h007F, 1'b0);
      drain("nch3_drain");
      repeat (4) @(posedge clk);
      #1;
      check(e3_cnt - b_e3 == 1, "nch3_err", e3_cnt - b_e3, 1);
      check(ov3_cnt - b_ov3 == 0, "nch3_no_ov", ov3_cnt - b_ov3, 0);
      check(p3_cnt - b_p3 == 0, "nch3_p_zero", p3_cnt - b_p3, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=%0t required=<200000", $time);
      $fatal(1, "bench timeout");
   end
endmodule
